cmos_capture_rgb565: RTL
========================

Name: cmos_capture_rgb565

Overview:
Camera front-end that sits directly upstream of the Sobel/UDP pipeline (cmos2sobel). It takes raw OV5640 DVP signals (vsync, href, 8-bit data), discards the first frames after reset, and packs byte pairs into RGB565 pixels. For each pixel it emits the x/y position and frame-start/frame-done strobes. It also measures the active width and height of each completed frame, which the downstream stage uses as cmos_h/cmos_v.

Parameters:
SKIP_FRAMES, 10, number of complete frames discarded after reset before capture starts (0 = capture from first vsync).
HW, 16, width of the x/y counters and the measured-size outputs.

Ports:
clk  in  1  pixel clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
cam_vsync  in  1  frame sync; a rising edge marks frame start.
cam_href  in  1  line valid, active-high.
cam_data  in  8  byte stream; high byte first, then low byte.
pix_valid  out  1  one-cycle strobe; pix_data/pix_x/pix_y are valid.
pix_data  out  16  RGB565 pixel {first byte, second byte}.
pix_x  out  HW  pixel column, 0-based.
pix_y  out  HW  pixel row, 0-based.
frame_start  out  1  pulse coincident with the first pix_valid of a captured frame.
frame_done  out  1  pulse on the vsync rise that closes a captured frame containing at least one pixel.
meas_h  out  HW  pixels in the last line of the last completed frame.
meas_v  out  HW  lines in the last completed frame.
cap_ready  out  1  high once skipping is finished (state S_RUN).
byte_err  out  1  pulse when href falls after an odd byte count.

Behaviour:
- Reset (async, rst=1): all outputs are 0, state is S_SKIP, and all counters, byte phase and input registers are cleared. Reset mid-frame drops the partial frame and emits no frame_done.
- Input stage: cam_vsync, cam_href and cam_data are registered once. Edge detection uses the registered values and their 1-cycle-delayed copies.
- Latency: pix_valid asserts exactly 2 clk after the edge at which the low byte is present on cam_data (1 cycle input register + 1 cycle output register).
- FSM, 2 states:
  - S_SKIP: on each vsync rise, if skip_cnt==SKIP_FRAMES go to S_RUN (that rise opens the first captured frame); otherwise skip_cnt++. pix_valid is held at 0.
  - S_RUN: stays there until reset. cap_ready=1.
- Byte packing (S_RUN, href high):
  - phase 0: latch byte as hi.
  - phase 1: output {hi, byte}, pulse pix_valid, pix_x = current x, then x++.
  - Phase toggles every cycle href is high.
- href fall:
  - If phase==1, pulse byte_err and discard the orphan byte.
  - phase=0, x=0.
  - If the line produced at least 1 pixel: y++ and latch line_w = x.
- vsync rise in S_RUN:
  - If the closing frame had at least 1 pixel: frame_done=1, meas_h=line_w, meas_v=y.
  - Then x=0, y=0, phase=0, first_pix=1.
  - vsync rise has priority over href: a line still active is aborted with no byte_err and no y increment.
- frame_start: asserted with the first pix_valid while first_pix=1, then first_pix is cleared.
- Saturation: x and y saturate at 2^HW-1 (no wrap). Pixels beyond saturation are still output with the saturated coordinate.
- Empty frame: two vsync rises with no pixels between them produce no frame_done, and meas_h/meas_v hold their values.
- href held low, or vsync held high: no output activity. Only rising edges of vsync matter; vsync level and pulse width are don't-care.
- Simultaneous href fall and vsync rise in the same cycle: vsync handling wins; no y increment, no byte_err.

Decomposition:
- Package cmos_cap_pkg: FSM state encoding (S_SKIP, S_RUN), PIX_W=16, BYTE_W=8.
- One sub-module, cmos_byte_pack: phase toggle, hi-byte latch, 16-bit output register and odd-byte detect. The top keeps the input register, edge detect, FSM, x/y counters and measurement.

Test Plan:
- Frame stimulus: frame period 601 clk, vsync high 1 cycle, 10 lines each with href high 20 cycles at 50-cycle spacing, cam_data=line index. With SKIP_FRAMES=2:
  - 1. No pix_valid during the first 2 frames.
  - 2. Frame 3 yields 100 pix_valid with pix_data=16'h0101 on line 1 through 16'h0A0A on line 10, pix_x 0..9, pix_y 0..9.
  - 3. On the next vsync rise: frame_done=1, meas_h=10, meas_v=10.
- SKIP_FRAMES=0: the first vsync rise gives cap_ready=1, and the first pixel arrives with frame_start=1 and pix_x=pix_y=0, 2 clk after its low byte.
- href high for 21 cycles on line 4 -> 10 pixels, then byte_err pulses once on the href fall; pix_y continues 4, 5, … and meas_h=10.
- vsync rise while href is high mid-line (after 6 bytes) -> 3 pixels are output, no byte_err, frame_done=1, meas_v counts only completed lines.
- Assert rst for 3 cycles mid-frame in S_RUN -> all outputs 0 immediately (async). The next 2 frames are skipped again, and there is no frame_done for the aborted frame.
- Two consecutive vsync rises with no href -> no frame_done pulse; meas_h/meas_v keep their previous values of 10/10.

Source files
------------

// File: rtl/cmos_cap_pkg.sv
// cmos_cap_pkg: shared state encoding and widths for the DVP RGB565 capture front-end
package cmos_cap_pkg;
  typedef enum logic {S_SKIP, S_RUN} state_t;
  localparam int PIX_W = 16;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/cmos_byte_pack.sv
// cmos_byte_pack: pairs DVP bytes into RGB565 words and flags a line that ends on an odd byte
module cmos_byte_pack
  import cmos_cap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              line_end,
  input  logic [BYTE_W-1:0] data,
  output logic              fire,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              byte_err
);
  logic              phase;
  logic [BYTE_W-1:0] hi;
  assign fire = en & phase;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase     <= 1'b0;
      hi        <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      byte_err  <= 1'b0;
    end else begin
      pix_valid <= fire;
      byte_err  <= line_end & phase;
      if (fire) pix_data <= {hi, data};
      if (en & ~phase) hi <= data;
      phase <= (clr | line_end) ? 1'b0 : en ? ~phase : phase;
    end
endmodule

// File: rtl/cmos_capture_rgb565.sv
// cmos_capture_rgb565: OV5640 DVP capture with frame skipping, pixel coordinates and frame size measurement
module cmos_capture_rgb565
  import cmos_cap_pkg::*;
#(
  parameter int SKIP_FRAMES = 10,
  parameter int HW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [BYTE_W-1:0] cam_data,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic [HW-1:0]     pix_x,
  output logic [HW-1:0]     pix_y,
  output logic              frame_start,
  output logic              frame_done,
  output logic [HW-1:0]     meas_h,
  output logic [HW-1:0]     meas_v,
  output logic              cap_ready,
  output logic              byte_err
);
  localparam int SW = $clog2(SKIP_FRAMES + 1) + 1;
  localparam logic [SW-1:0] SKIP_N = SW'(SKIP_FRAMES);
  localparam logic [HW-1:0] CMAX = '1;
  state_t            state;
  logic              vs_r, vs_d, hr_r, hr_d;
  logic [BYTE_W-1:0] d_r;
  logic [SW-1:0]     skip_cnt;
  logic [HW-1:0]     x, y, line_w, x_nx, y_nx;
  logic              first_pix, has_pix, fire;
  logic              vs_rise, hr_fall, run, en, line_end;
  assign vs_rise  = vs_r & ~vs_d;
  assign hr_fall  = hr_d & ~hr_r;
  assign run      = state == S_RUN;
  // a vsync rise overrides any href activity in the same cycle
  assign en       = run & hr_r & ~vs_rise;
  assign line_end = run & hr_fall & ~vs_rise;
  assign x_nx     = (x == CMAX) ? x : x + 1'b1;
  assign y_nx     = (y == CMAX) ? y : y + 1'b1;
  cmos_byte_pack u_pack (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (vs_rise),
    .line_end (line_end),
    .data     (d_r),
    .fire     (fire),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .byte_err (byte_err)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= S_SKIP;
      {vs_r, vs_d, hr_r, hr_d} <= '0;
      d_r         <= '0;
      skip_cnt    <= '0;
      {x, y, line_w, pix_x, pix_y, meas_h, meas_v} <= '0;
      {first_pix, has_pix, frame_start, frame_done, cap_ready} <= '0;
    end else begin
      vs_r        <= cam_vsync;
      vs_d        <= vs_r;
      hr_r        <= cam_href;
      hr_d        <= hr_r;
      d_r         <= cam_data;
      frame_done  <= 1'b0;
      frame_start <= 1'b0;
      if (!run) begin
        if (vs_rise && skip_cnt == SKIP_N) begin
          state     <= S_RUN;
          cap_ready <= 1'b1;
          first_pix <= 1'b1;
        end else if (vs_rise) skip_cnt <= skip_cnt + 1'b1;
      end else if (vs_rise) begin
        if (has_pix) begin
          frame_done <= 1'b1;
          meas_h     <= line_w;
          meas_v     <= y;
        end
        x         <= '0;
        y         <= '0;
        first_pix <= 1'b1;
        has_pix   <= 1'b0;
      end else if (line_end) begin
        x <= '0;
        if (x != '0) begin
          y      <= y_nx;
          line_w <= x;
        end
      end else if (fire) begin
        pix_x       <= x;
        pix_y       <= y;
        x           <= x_nx;
        frame_start <= first_pix;
        first_pix   <= 1'b0;
        has_pix     <= 1'b1;
      end
    end
endmodule
